// File: rtl/svc_rv_btb_pkg.sv
// ---------------------------------------------------------------------------
// svc_rv_btb_pkg
// Shared constants and helpers for the set-associative branch target buffer.
// Holds the 2-bit direction counter encodings and the saturating counter
// arithmetic. The arithmetic works for any width up to CNT_MAX_W.
// ---------------------------------------------------------------------------
package svc_rv_btb_pkg;

   // Widest direction counter the helper functions can handle
   localparam int CNT_MAX_W = 8;

   // Named states of the classic 2-bit predictor
   localparam logic [1:0] CNT_SNT = 2'd0;
   localparam logic [1:0] CNT_WNT = 2'd1;
   localparam logic [1:0] CNT_WT  = 2'd2;
   localparam logic [1:0] CNT_ST  = 2'd3;

   // All-ones value for a counter of width cntW
   function automatic logic [CNT_MAX_W-1:0] cntMax(input int unsigned cntW);
      return CNT_MAX_W'((1 << cntW) - 1);
   endfunction

   // Increment on taken and decrement on not-taken, clamping at both ends
   function automatic logic [CNT_MAX_W-1:0] cntNext(input logic [CNT_MAX_W-1:0] cnt,
                                                    input logic taken,
                                                    input int unsigned cntW);
      logic [CNT_MAX_W-1:0] maxVal;
      maxVal = cntMax(cntW);
      if (taken)
         return (cnt == maxVal) ? cnt : cnt + CNT_MAX_W'(1);
      else
         return (cnt == '0) ? cnt : cnt - CNT_MAX_W'(1);
   endfunction

   // Value for a freshly allocated entry: weakly taken, or saturated for jumps
   function automatic logic [CNT_MAX_W-1:0] cntInit(input logic uncond,
                                                    input int unsigned cntW);
      if (cntW == 2)
         return uncond ? CNT_MAX_W'(CNT_ST) : CNT_MAX_W'(CNT_WT);
      return uncond ? cntMax(cntW) : (CNT_MAX_W'(1) << (cntW - 1));
   endfunction

endpackage

// File: rtl/svc_rv_btb_assoc_if.sv
// ---------------------------------------------------------------------------
// svc_rv_btb_assoc_if
// Bundles the fetch-side lookup and resolve-side update signals of the BTB.
//   master : core side, drives lookup/update/flush, receives the prediction
//   slave  : BTB side
// Signals: lookup_en, lookup_pc, hit, pred_taken, pred_target, update_en,
//          update_pc, update_target, update_taken, update_uncond, flush
// ---------------------------------------------------------------------------
interface svc_rv_btb_assoc_if #(
   parameter int XLEN = 32
);
   logic            lookup_en;
   logic [XLEN-1:0] lookup_pc;
   logic            hit;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            update_en;
   logic [XLEN-1:0] update_pc;
   logic [XLEN-1:0] update_target;
   logic            update_taken;
   logic            update_uncond;
   logic            flush;

   modport master (
      output lookup_en, lookup_pc, update_en, update_pc, update_target,
             update_taken, update_uncond, flush,
      input  hit, pred_taken, pred_target
   );

   modport slave (
      input  lookup_en, lookup_pc, update_en, update_pc, update_target,
             update_taken, update_uncond, flush,
      output hit, pred_taken, pred_target
   );
endinterface

// File: rtl/svc_rv_btb_way.sv
// ---------------------------------------------------------------------------
// svc_rv_btb_way
// One way of the BTB: per-set valid, tag, target and direction counter.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears valids)
//   i_flush               clear every valid bit
//   i_lkIdx/i_lkTag       lookup read port -> o_lkHit, o_lkTaken, o_lkTarget
//   i_upIdx/i_upTag       update read port -> o_upHit, o_upValid,
//                         o_upTarget, o_upCnt
//   i_wrEn, i_wrTarget,   write a full entry at i_upIdx with tag i_upTag
//   i_wrCnt
// ---------------------------------------------------------------------------
module svc_rv_btb_way #(
   parameter int XLEN   = 32,
   parameter int SETS   = 8,
   parameter int IDX_WC = 3,
   parameter int TAG_W  = 27,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_flush,
   input  logic [IDX_WC-1:0] i_lkIdx,
   input  logic [TAG_W-1:0]  i_lkTag,
   output logic              o_lkHit,
   output logic              o_lkTaken,
   output logic [XLEN-1:0]   o_lkTarget,
   input  logic [IDX_WC-1:0] i_upIdx,
   input  logic [TAG_W-1:0]  i_upTag,
   output logic              o_upHit,
   output logic              o_upValid,
   output logic [XLEN-1:0]   o_upTarget,
   output logic [CNT_W-1:0]  o_upCnt,
   input  logic              i_wrEn,
   input  logic [XLEN-1:0]   i_wrTarget,
   input  logic [CNT_W-1:0]  i_wrCnt
);

   logic [SETS-1:0]  r_valid;
   logic [TAG_W-1:0] r_tag    [SETS];
   logic [XLEN-1:0]  r_target [SETS];
   logic [CNT_W-1:0] r_cnt    [SETS];

   // Valid bits are the only per-entry state that needs a reset value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_valid <= '0;
      else if (i_flush)
         r_valid <= '0;
      else if (i_wrEn)
         r_valid[i_upIdx] <= 1'b1;
   end

   // Payload is only meaningful behind a valid bit, so it needs no reset
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_tag[i_upIdx]    <= i_upTag;
         r_target[i_upIdx] <= i_wrTarget;
         r_cnt[i_upIdx]    <= i_wrCnt;
      end
   end

   assign o_lkHit    = r_valid[i_lkIdx] && (r_tag[i_lkIdx] == i_lkTag);
   assign o_lkTaken  = r_cnt[i_lkIdx][CNT_W-1];
   assign o_lkTarget = r_target[i_lkIdx];

   assign o_upValid  = r_valid[i_upIdx];
   assign o_upHit    = r_valid[i_upIdx] && (r_tag[i_upIdx] == i_upTag);
   assign o_upTarget = r_target[i_upIdx];
   assign o_upCnt    = r_cnt[i_upIdx];

endmodule

// File: rtl/svc_rv_btb_assoc.sv
// ---------------------------------------------------------------------------
// svc_rv_btb_assoc
// N-way set-associative branch target buffer beside the fetch stage.
// Lookup on the fetch PC gives a registered prediction one cycle later;
// the resolve stage trains counters/targets and allocates on taken misses,
// using round-robin replacement once a set is full.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   btb          svc_rv_btb_assoc_if.slave (lookup, prediction, update, flush)
// ---------------------------------------------------------------------------
module svc_rv_btb_assoc
   import svc_rv_btb_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int WAYS    = 2,
   parameter int CNT_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   svc_rv_btb_assoc_if.slave btb
);

   localparam int SETS   = ENTRIES / WAYS;
   localparam int IDX_W  = $clog2(SETS);
   localparam int IDX_WC = (IDX_W > 0) ? IDX_W : 1;
   localparam int TAG_W  = XLEN - IDX_W - 2;
   localparam int PTR_WC = (WAYS > 1) ? $clog2(WAYS) : 1;

   if ((ENTRIES < 1) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_badEntries
      $error("svc_rv_btb_assoc: ENTRIES must be a power of two");
   end
   if ((WAYS < 1) || ((WAYS & (WAYS - 1)) != 0) || (WAYS > ENTRIES)) begin : g_badWays
      $error("svc_rv_btb_assoc: WAYS must be a power of two no larger than ENTRIES");
   end
   if ((CNT_W < 2) || (CNT_W > CNT_MAX_W)) begin : g_badCnt
      $error("svc_rv_btb_assoc: CNT_W out of range");
   end

   logic [IDX_WC-1:0] w_lkIdx, w_upIdx;
   logic [TAG_W-1:0]  w_lkTag, w_upTag;
   logic              w_unusedPcBits;

   // Index and tag come from shifts so a zero-width index (fully associative)
   // needs no special slicing
   assign w_lkIdx = IDX_WC'((btb.lookup_pc >> 2) & XLEN'(SETS - 1));
   assign w_upIdx = IDX_WC'((btb.update_pc >> 2) & XLEN'(SETS - 1));
   assign w_lkTag = TAG_W'(btb.lookup_pc >> (IDX_W + 2));
   assign w_upTag = TAG_W'(btb.update_pc >> (IDX_W + 2));
   assign w_unusedPcBits = ^{btb.lookup_pc[1:0], btb.update_pc[1:0]};

   logic [WAYS-1:0]  w_lkHitV, w_lkTakenV, w_upHitV, w_upValV, w_wrEnV;
   logic [XLEN-1:0]  w_lkTgtA [WAYS];
   logic [XLEN-1:0]  w_upTgtA [WAYS];
   logic [CNT_W-1:0] w_upCntA [WAYS];
   logic [XLEN-1:0]  w_wrTarget;
   logic [CNT_W-1:0] w_wrCnt;

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      svc_rv_btb_way #(
         .XLEN(XLEN), .SETS(SETS), .IDX_WC(IDX_WC), .TAG_W(TAG_W), .CNT_W(CNT_W)
      ) u_way (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_flush    (btb.flush),
         .i_lkIdx    (w_lkIdx),
         .i_lkTag    (w_lkTag),
         .o_lkHit    (w_lkHitV[g]),
         .o_lkTaken  (w_lkTakenV[g]),
         .o_lkTarget (w_lkTgtA[g]),
         .i_upIdx    (w_upIdx),
         .i_upTag    (w_upTag),
         .o_upHit    (w_upHitV[g]),
         .o_upValid  (w_upValV[g]),
         .o_upTarget (w_upTgtA[g]),
         .o_upCnt    (w_upCntA[g]),
         .i_wrEn     (w_wrEnV[g]),
         .i_wrTarget (w_wrTarget),
         .i_wrCnt    (w_wrCnt)
      );
   end

   logic              w_lkHit, w_lkTaken, w_upHit, w_anyFree;
   logic [XLEN-1:0]   w_lkTgt, w_upTgt;
   logic [CNT_W-1:0]  w_upCnt;
   logic [PTR_WC-1:0] w_upWay, w_freeWay, w_allocWay, w_wrSel;
   logic [PTR_WC-1:0] r_rrPtr [SETS];

   // Hit muxes for both read ports; the descending scan leaves the
   // lowest-numbered invalid way as the fill candidate
   always_comb begin
      w_lkHit   = 1'b0;
      w_lkTaken = 1'b0;
      w_lkTgt   = '0;
      w_upHit   = 1'b0;
      w_upWay   = '0;
      w_upTgt   = '0;
      w_upCnt   = '0;
      w_anyFree = 1'b0;
      w_freeWay = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (w_lkHitV[w]) begin
            w_lkHit   = 1'b1;
            w_lkTaken = w_lkTakenV[w];
            w_lkTgt   = w_lkTgtA[w];
         end
         if (w_upHitV[w]) begin
            w_upHit = 1'b1;
            w_upWay = PTR_WC'(w);
            w_upTgt = w_upTgtA[w];
            w_upCnt = w_upCntA[w];
         end
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!w_upValV[w]) begin
            w_anyFree = 1'b1;
            w_freeWay = PTR_WC'(w);
         end
      end
   end

   logic w_doUpd, w_wrAny, w_rrAdvance;

   // A hit retrains in place; a taken miss fills a free way or the victim
   assign w_doUpd     = btb.update_en & ~btb.flush;
   assign w_wrAny     = w_doUpd & (w_upHit | btb.update_taken);
   assign w_allocWay  = w_anyFree ? w_freeWay : r_rrPtr[w_upIdx];
   assign w_wrSel     = w_upHit ? w_upWay : w_allocWay;
   assign w_rrAdvance = w_doUpd & ~w_upHit & btb.update_taken & ~w_anyFree;
   assign w_wrTarget  = btb.update_taken ? btb.update_target : w_upTgt;
   assign w_wrCnt     = !w_upHit      ? CNT_W'(cntInit(btb.update_uncond, CNT_W)) :
                        btb.update_uncond ? CNT_W'(cntMax(CNT_W)) :
                        CNT_W'(cntNext(CNT_MAX_W'(w_upCnt), btb.update_taken, CNT_W));

   for (genvar g = 0; g < WAYS; g++) begin : g_wrEn
      assign w_wrEnV[g] = w_wrAny & (w_wrSel == PTR_WC'(g));
   end

   // Round-robin victim pointer per set, only stepped by replacements
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) r_rrPtr[s] <= '0;
      end else if (btb.flush) begin
         for (int s = 0; s < SETS; s++) r_rrPtr[s] <= '0;
      end else if (w_rrAdvance) begin
         r_rrPtr[w_upIdx] <= (r_rrPtr[w_upIdx] == PTR_WC'(WAYS - 1)) ? '0
                             : r_rrPtr[w_upIdx] + PTR_WC'(1);
      end
   end

   logic            r_hit, r_predTaken;
   logic [XLEN-1:0] r_predTarget;

   // Registered prediction; holds while fetch is stalled, reads as a miss
   // when a flush lands in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit        <= 1'b0;
         r_predTaken  <= 1'b0;
         r_predTarget <= '0;
      end else if (btb.lookup_en) begin
         r_hit        <= w_lkHit & ~btb.flush;
         r_predTaken  <= w_lkHit & w_lkTaken & ~btb.flush;
         r_predTarget <= btb.flush ? '0 : w_lkTgt;
      end
   end

   assign btb.hit         = r_hit;
   assign btb.pred_taken  = r_predTaken;
   assign btb.pred_target = r_predTarget;

endmodule
